mux_stage: RTL and testbench

Parametrised N-way data selector with a registered valid/ready output stage. It is the pipelined successor of the fixed 3-input combinational selector. It sits at pipeline boundaries in the CPU datapath: forwarding select into EX, writeback-source select, PC-source select. It is a drop-in when a select must be registered and must respect downstream back-pressure, stall and flush.

---
 rtl/mux_pkg.sv | 23 ++
 rtl/mux_skid_buf.sv | 96 +++++++++
 rtl/mux_stage.sv | 94 +++++++++
 tb/tb_mux_stage.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared types and helpers for the mux_stage registered data selector.
package mux_pkg;

    localparam int unsigned MUX_MAX_IN = 16;

    // Occupancy of the output stage (skid build): out reg and skid register.
    typedef enum logic [1:0] {
        OccEmpty = 2'd0,
        OccOne   = 2'd1,
        OccFull  = 2'd2
    } mux_occ_e;

    function automatic int unsigned sel_width(input int unsigned n);
        int unsigned w;
        if (n <= 2) begin
            w = 1;
        end else begin
            w = int'($clog2(n));
        end
        return w;
    endfunction

endpackage

// File: rtl/mux_skid_buf.sv
// Generic two-entry valid/ready skid register; upstream ready comes straight from a flop.
module mux_skid_buf
    import mux_pkg::*;
#(
    parameter int unsigned DW = 33
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          i_flush,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [DW-1:0] i_data,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [DW-1:0] o_data
);

    mux_occ_e r_state;
    mux_occ_e w_state_next;

    logic          r_ready;
    logic [DW-1:0] r_out_data;
    logic [DW-1:0] r_skid_data;

    logic w_accept;
    logic w_consume;
    logic w_load_out;
    logic w_load_skid;
    logic w_skid_to_out;

    assign w_accept  = i_valid && r_ready;
    assign w_consume = (r_state != OccEmpty) && i_ready;

    always_comb begin
        w_state_next  = r_state;
        w_load_out    = 1'b0;
        w_load_skid   = 1'b0;
        w_skid_to_out = 1'b0;
        unique case (r_state)
            OccEmpty: begin
                if (w_accept) begin
                    w_state_next = OccOne;
                    w_load_out   = 1'b1;
                end
            end
            OccOne: begin
                if (w_accept && w_consume) begin
                    w_load_out = 1'b1;
                end else if (w_accept) begin
                    w_state_next = OccFull;
                    w_load_skid  = 1'b1;
                end else if (w_consume) begin
                    w_state_next = OccEmpty;
                end
            end
            OccFull: begin
                // r_ready is low here, so only a consume can happen.
                if (w_consume) begin
                    w_state_next  = OccOne;
                    w_skid_to_out = 1'b1;
                end
            end
            default: begin
                w_state_next = OccEmpty;
            end
        endcase
        if (i_flush) begin
            w_state_next = OccEmpty;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= OccEmpty;
            r_ready     <= 1'b1;
            r_out_data  <= '0;
            r_skid_data <= '0;
        end else begin
            r_state <= w_state_next;
            r_ready <= (w_state_next != OccFull);
            if (w_load_out) begin
                r_out_data <= i_data;
            end else if (w_skid_to_out) begin
                r_out_data <= r_skid_data;
            end
            if (w_load_skid) begin
                r_skid_data <= i_data;
            end
        end
    end

    assign o_ready = r_ready;
    assign o_valid = (r_state != OccEmpty);
    assign o_data  = r_out_data;

endmodule

// File: rtl/mux_stage.sv
// N-way data selector with a registered valid/ready output stage.
// Define MUX_STAGE_SKID_EN for the skid-buffered build with registered in_ready.
module mux_stage
    import mux_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NUM_IN = 3,
    localparam int unsigned SEL_W = sel_width(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SEL_W-1:0]        sel,
    input  logic [NUM_IN*WIDTH-1:0] d,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_sel_err
);

    logic [WIDTH-1:0] w_sel_data;
    logic             w_sel_err;

    // Out-of-range selects fall back to input 0 and flag the beat.
    always_comb begin
        w_sel_err  = (int'(sel) >= int'(NUM_IN));
        w_sel_data = d[WIDTH-1:0];
        for (int k = 1; k < int'(NUM_IN); k++) begin
            if (int'(sel) == k) begin
                w_sel_data = d[k*WIDTH +: WIDTH];
            end
        end
    end

`ifdef MUX_STAGE_SKID_EN

    logic [WIDTH:0] w_skid_out;

    mux_skid_buf #(
        .DW(WIDTH + 1)
    ) u_skid_buf (
        .clk     (clk),
        .resetn  (resetn),
        .i_flush (flush),
        .i_valid (in_valid),
        .o_ready (in_ready),
        .i_data  ({w_sel_err, w_sel_data}),
        .o_valid (out_valid),
        .i_ready (out_ready),
        .o_data  (w_skid_out)
    );

    assign out_sel_err = w_skid_out[WIDTH];
    assign out_data    = w_skid_out[WIDTH-1:0];

`else

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic             r_err;
    logic             w_accept;

    assign in_ready = !r_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_err   <= 1'b0;
        end else begin
            if (flush) begin
                r_valid <= 1'b0;
            end else if (w_accept) begin
                r_valid <= 1'b1;
            end else if (out_ready) begin
                r_valid <= 1'b0;
            end
            if (w_accept) begin
                r_data <= w_sel_data;
                r_err  <= w_sel_err;
            end
        end
    end

    assign out_valid   = r_valid;
    assign out_data    = r_data;
    assign out_sel_err = r_err;

`endif

endmodule

// File: tb/tb_mux_stage.sv
// Directed self-checking bench for mux_stage (NUM_IN=3 main instance, NUM_IN=4 side instance).
module tb_mux_stage;

`ifdef MUX_STAGE_SKID_EN
    localparam logic EXP_RDY_AFTER_ONE = 1'b1;
`else
    localparam logic EXP_RDY_AFTER_ONE = 1'b0;
`endif

    logic        clk;
    logic        resetn;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  sel;
    logic [95:0] d3;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_sel_err;

    logic         in_valid4;
    logic         in_ready4;
    logic [1:0]   sel4;
    logic [127:0] d4;
    logic         out_valid4;
    logic [31:0]  out_data4;
    logic         out_sel_err4;

    int n_checks = 0;
    int n_fail   = 0;

    mux_stage #(
        .WIDTH  (32),
        .NUM_IN (3)
    ) u_dut (
        .clk         (clk),
        .resetn      (resetn),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .sel         (sel),
        .d           (d3),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_sel_err (out_sel_err)
    );

    mux_stage #(
        .WIDTH  (32),
        .NUM_IN (4)
    ) u_dut4 (
        .clk         (clk),
        .resetn      (resetn),
        .flush       (1'b0),
        .in_valid    (in_valid4),
        .in_ready    (in_ready4),
        .sel         (sel4),
        .d           (d4),
        .out_valid   (out_valid4),
        .out_ready   (1'b1),
        .out_data    (out_data4),
        .out_sel_err (out_sel_err4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d0(input logic [31:0] beat);
        d3 = {32'h33, 32'h22, beat};
    endtask

    logic [31:0] bp_beats [4];
    int          beat_idx;
    int          got;
    logic        acc;
    logic        cons;

    initial begin
        resetn    = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        sel       = 2'd0;
        out_ready = 1'b1;
        set_d0(32'h11);
        in_valid4 = 1'b0;
        sel4      = 2'd0;
        d4        = {32'h44, 32'h33, 32'h22, 32'h11};
        bp_beats  = '{32'hA0, 32'hB0, 32'hC0, 32'hD0};

        #12;
        resetn = 1'b1;
        #1;
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_data", out_data, 0);
        check_eq("rst_sel_err", out_sel_err, 0);
        check_eq("rst_in_ready", in_ready, 1);
        tick();

        // Selection sweep with out_ready high.
        in_valid = 1'b1;
        sel = 2'd1;
        tick();
        check_eq("sel1_valid", out_valid, 1);
        check_eq("sel1_data", out_data, 32'h22);
        check_eq("sel1_err", out_sel_err, 0);
        sel = 2'd2;
        tick();
        check_eq("sel2_data", out_data, 32'h33);
        check_eq("sel2_err", out_sel_err, 0);
        sel = 2'd0;
        tick();
        check_eq("sel0_data", out_data, 32'h11);
        sel = 2'd3;
        tick();
        check_eq("sel3_data", out_data, 32'h11);
        check_eq("sel3_err", out_sel_err, 1);
        in_valid = 1'b0;
        tick();
        check_eq("drain_valid", out_valid, 0);

        // NUM_IN=4: sel=3 is legal.
        in_valid4 = 1'b1;
        sel4 = 2'd3;
        tick();
        check_eq("n4_sel3_data", out_data4, 32'h44);
        check_eq("n4_sel3_err", out_sel_err4, 0);
        sel4 = 2'd1;
        tick();
        check_eq("n4_sel1_data", out_data4, 32'h22);
        in_valid4 = 1'b0;

        // Back-pressure: A..D offered back to back, out_ready low for 3 cycles.
        beat_idx = 0;
        got = 0;
        sel = 2'd0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            out_ready = (cyc >= 3);
            in_valid  = (beat_idx < 4);
            set_d0(bp_beats[(beat_idx < 4) ? beat_idx : 3]);
            @(negedge clk);
            acc  = in_valid && in_ready;
            cons = out_valid && out_ready;
            if (cyc == 1) begin
                check_eq("bp_ready_c1", in_ready, EXP_RDY_AFTER_ONE);
                check_eq("bp_hold_c1", out_data, 32'hA0);
            end
            if (cyc == 2) begin
                check_eq("bp_ready_c2", in_ready, 0);
                check_eq("bp_hold_c2", out_data, 32'hA0);
            end
            if (cons) begin
                if (got < 4) check_eq("bp_order", out_data, bp_beats[got]);
                got++;
            end
            if (acc) beat_idx++;
            tick();
        end
        in_valid = 1'b0;
        check_eq("bp_count", got, 4);
        check_eq("bp_end_valid", out_valid, 0);

        // Flush with one beat held, colliding with an accept and a consume.
        in_valid  = 1'b1;
        set_d0(32'hE0);
        out_ready = 1'b0;
        tick();
        check_eq("fl1_loaded", out_data, 32'hE0);
        flush     = 1'b1;
        set_d0(32'h66);
        out_ready = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check_eq("fl1_valid", out_valid, 0);
        check_eq("fl1_ready", in_ready, 1);
        tick();
        check_eq("fl1_dropped", out_valid, 0);

        // Flush with the stage filled and another beat offered.
        in_valid  = 1'b1;
        set_d0(32'hE1);
        out_ready = 1'b0;
        tick();
        set_d0(32'hF1);
        tick();
        check_eq("fl2_hold", out_data, 32'hE1);
        flush = 1'b1;
        set_d0(32'h77);
        tick();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check_eq("fl2_valid", out_valid, 0);
        check_eq("fl2_ready", in_ready, 1);
        tick();
        check_eq("fl2_dropped", out_valid, 0);

        // Asynchronous reset mid-cycle while filled.
        in_valid  = 1'b1;
        set_d0(32'hE2);
        out_ready = 1'b0;
        tick();
        set_d0(32'hF2);
        tick();
        in_valid = 1'b0;
        #3;
        resetn = 1'b0;
        #1;
        check_eq("arst_valid", out_valid, 0);
        check_eq("arst_data", out_data, 0);
        check_eq("arst_err", out_sel_err, 0);
        check_eq("arst_ready", in_ready, 1);
        tick();
        resetn    = 1'b1;
        in_valid  = 1'b1;
        set_d0(32'h5A);
        out_ready = 1'b1;
        tick();
        check_eq("post_rst_valid", out_valid, 1);
        check_eq("post_rst_data", out_data, 32'h5A);
        in_valid = 1'b0;
        tick();
        check_eq("post_rst_drain", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
